// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter feeding a shared 4:1 select path.
// Each cycle it picks one requester, starting the search at a rotating priority pointer.
// The chosen operand is registered into a single valid/ready output slot.
// The slot reloads on the same edge it drains, so a steady stream moves one item per cycle.
module mux4_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            state, state_nxt;
  logic [1:0]       ptr;
  logic             load_en;
  logic             win_found;
  logic [1:0]       win_idx;
  logic             take;
  logic [WIDTH-1:0] win_data;

  // Slot may accept a new item when empty or when its current item leaves this edge
  assign load_en = (state == EMPTY) || out_ready;

  // Rotating priority scan: first set request at ptr, ptr+1, ptr+2, ptr+3 (mod 4)
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_idx   = ptr;
    idx       = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Grant is held off during reset so nothing is issued while state is being cleared
  always_comb begin
    gnt = 4'b0000;
    if (rst_n && load_en && win_found) gnt = 4'b0001 << win_idx;
  end

  assign take = |gnt;

  // Operand steering for the winning requester
  always_comb begin
    win_data = data_a;
    case (win_idx)
      2'd0: win_data = data_a;
      2'd1: win_data = data_b;
      2'd2: win_data = data_c;
      2'd3: win_data = data_d;
      default: win_data = data_a;
    endcase
  end

  // Slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Slot next state: a load always fills; a drain with nothing to reload empties
  always_comb begin
    state_nxt = state;
    if (take)                          state_nxt = FULL;
    else if (state == FULL && out_ready) state_nxt = EMPTY;
  end

  // Slot outputs
  always_comb begin
    out_valid = (state == FULL);
  end

  // Capture winner data/select and advance the pointer just past the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      sel      <= 2'b00;
      ptr      <= 2'b00;
    end else if (take) begin
      out_data <= win_data;
      sel      <= win_idx;
      ptr      <= win_idx + 2'd1;
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 selection path: four requesters each present a WIDTH-bit operand, and the block picks one per cycle.
- It drives the 2-bit select code of the 4:1 datapath and registers the selected operand into a single output slot with valid/ready flow control.
- It sits between the per-source producers and the single downstream consumer of the shared mux. It replaces ad-hoc static select decoding with fair, back-pressured sharing.

Parameters:
- WIDTH, 32, bit width of each requester's data and of out_data.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset: assertion clears state immediately; deassertion is synchronous to clk.
- req  input  4  request vector; req[i] means requester i has valid data on data_i.
- data_a  input  WIDTH  requester 0 operand (select code 2'b00).
- data_b  input  WIDTH  requester 1 operand (select code 2'b01).
- data_c  input  WIDTH  requester 2 operand (select code 2'b10).
- data_d  input  WIDTH  requester 3 operand (select code 2'b11).
- gnt  output  4  one-hot grant, combinational. Requester i's transfer completes on a rising edge where req[i] and gnt[i] are both 1.
- sel  output  2  registered select code of the requester whose data is held in out_data.
- out_valid  output  1  out_data holds an unconsumed item.
- out_data  output  WIDTH  registered selected operand.
- out_ready  input  1  consumer accepts out_data on a rising edge where out_valid and out_ready are both 1.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, sel=2'b00, priority pointer ptr=0. gnt is forced to 4'b0000 while rst_n=0.
- Slot state, 2 states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load enable: load_en = (EMPTY) or (FULL and out_ready).
- Grant rules:
  - gnt is nonzero only when load_en=1 and req is not 0000.
  - The winner is the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - Exactly one gnt bit is set; gnt never asserts for a bit whose req is 0.
- On a rising edge with load_en and any req:
  - out_data <= data of winner; sel <= winner index; out_valid <= 1.
  - ptr <= (winner + 1) mod 4, so the pointer wraps from 3 to 0.
- On a rising edge with FULL, out_ready=1 and req=0000: out_valid <= 0. out_data and sel hold their last values.
- Throughput and latency:
  - Back-to-back operation: drain and reload happen on the same edge, giving one item per cycle.
  - Latency from grant edge to out_valid is 1 cycle; no combinational path from req to out_data.
- Back-pressure: FULL with out_ready=0 gives gnt=0000, and out_data, sel, out_valid and ptr are held stable.
- Pointer update: ptr changes only on a load; a cycle with no grant leaves it unchanged.
- Requester obligations: a requester holds req and data stable until granted. A requester dropping req before grant is legal; it simply loses its turn and nothing is captured for it.
- out_ready while EMPTY is ignored.
- Reset mid-operation: a held item is discarded (out_valid=0) and ptr returns to 0. No gnt is issued during reset or on the edge where reset deasserts.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid, out_data, sel and gnt go to 0 immediately without waiting for clk; after release with req=0000, out_valid stays 0.
- Single requester: req=0100, data_c=32'hDEADBEEF, out_ready=1 -> gnt=0100 that cycle; next cycle out_valid=1, sel=2'b10, out_data=32'hDEADBEEF. ptr=3 afterwards.
- Fairness with wrap: req=1111 held, out_ready=1, data_a..d=1,2,3,4 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; out_data sequence 1,2,3,4,1 one cycle later each; sel goes 0,1,2,3,0.
- Back-pressure: FULL holding data_b=32'h5, out_ready=0 for 3 cycles with req=1111 -> gnt=0000, and out_data=5 and sel=01 stable all 3 cycles. When out_ready returns to 1, the next grant is 0100.
- Pointer skip and wrap: ptr=3, req=1001 -> gnt=1000, then ptr=0 and gnt=0001. Then req=0000 with out_ready=1 -> out_valid drops to 0 and ptr remains 1.
- Reset mid-stream: req=1111 streaming, pulse rst_n low for 1 cycle -> out_valid=0. After release the first grant is 0001 (ptr=0), regardless of the pre-reset pointer.
